// File: rtl/sdp_x_pkg.sv
// Shared types and constants for the SDP X-datapath stages.
// Lane width, ALU algorithm and precision encodings, saturation limits.
package sdp_x_pkg;

    localparam int LANE_W = 32;
    localparam int OP_W   = 16;

    typedef enum logic [1:0] {
        SUM = 2'd0,
        MAX = 2'd1,
        MIN = 2'd2
    } alu_algo_e;

    localparam logic [1:0] PREC_INT8  = 2'd0;
    localparam logic [1:0] PREC_INT16 = 2'd1;
    localparam logic [1:0] PREC_INT32 = 2'd2;

    localparam logic signed [LANE_W:0] INT8_MAX  = 33'sd127;
    localparam logic signed [LANE_W:0] INT8_MIN  = -33'sd128;
    localparam logic signed [LANE_W:0] INT16_MAX = 33'sd32767;
    localparam logic signed [LANE_W:0] INT16_MIN = -33'sd32768;
    localparam logic signed [LANE_W:0] INT32_MAX = 33'sh0_7FFF_FFFF;
    localparam logic signed [LANE_W:0] INT32_MIN = 33'sh1_8000_0000;

    localparam logic signed [47:0] OPX_MAX = 48'sh0000_7FFF_FFFF;
    localparam logic signed [47:0] OPX_MIN = 48'shFFFF_8000_0000;

    // Sign-extend and shift the operand at 48 bits, then clamp to int32.
    function automatic logic [LANE_W-1:0] op_scale(
        input logic [OP_W-1:0] op,
        input logic [4:0]      shift
    );
        logic signed [47:0] ext;
        logic signed [47:0] shd;
        logic [LANE_W-1:0]  r;
        ext = {{(48-OP_W){op[OP_W-1]}}, op};
        shd = ext <<< shift;
        if (shd > OPX_MAX)
            r = 32'h7FFF_FFFF;
        else if (shd < OPX_MIN)
            r = 32'h8000_0000;
        else
            r = shd[LANE_W-1:0];
        return r;
    endfunction

endpackage

// File: rtl/sdp_x_alu_lane.sv
// Single-lane combinational ALU: SUM with precision saturation,
// signed MAX/MIN, or bypass.
module sdp_x_alu_lane
    import sdp_x_pkg::*;
(
    input  logic [LANE_W-1:0] data,
    input  logic [LANE_W-1:0] op,
    input  logic [1:0]        algo,
    input  logic [1:0]        prec,
    input  logic              bypass,
    output logic [LANE_W-1:0] result
);

    logic signed [LANE_W-1:0] a;
    logic signed [LANE_W-1:0] b;
    logic signed [LANE_W:0]   sum;
    logic signed [LANE_W:0]   hi;
    logic signed [LANE_W:0]   lo;

    assign a   = $signed(data);
    assign b   = $signed(op);
    assign sum = $signed({a[LANE_W-1], a}) + $signed({b[LANE_W-1], b});

    // Saturation window selected by precision; 2 and 3 both mean int32.
    always_comb begin
        hi = INT32_MAX;
        lo = INT32_MIN;
        case (prec)
            PREC_INT8: begin
                hi = INT8_MAX;
                lo = INT8_MIN;
            end
            PREC_INT16: begin
                hi = INT16_MAX;
                lo = INT16_MIN;
            end
            default: ;
        endcase
    end

    // Per-lane result; reserved algo code falls through to SUM.
    always_comb begin
        result = data;
        if (!bypass) begin
            case (algo)
                MAX: result = (a > b) ? data : op;
                MIN: result = (a < b) ? data : op;
                default: begin
                    if (sum > hi)
                        result = hi[LANE_W-1:0];
                    else if (sum < lo)
                        result = lo[LANE_W-1:0];
                    else
                        result = sum[LANE_W-1:0];
                end
            endcase
        end
    end

endmodule

// File: rtl/sdp_x_alu_stage.sv
// X-datapath ALU stage: two-stage pipe with vz/lz backpressure.
// Optional stall counter port enabled by SDP_X_ALU_PERF_CNT_EN.
module sdp_x_alu_stage
    import sdp_x_pkg::*;
#(
    parameter int LANES = 16
) (
    input  logic                    nvdla_core_clk,
    input  logic                    nvdla_core_rst,
    input  logic [LANES*LANE_W-1:0] chn_alu_in_rsc_z,
    input  logic                    chn_alu_in_rsc_vz,
    output logic                    chn_alu_in_rsc_lz,
    input  logic                    cfg_alu_bypass,
    input  logic [1:0]              cfg_alu_algo,
    input  logic [OP_W-1:0]         cfg_alu_op,
    input  logic [4:0]              cfg_alu_shift_value,
    input  logic [1:0]              cfg_precision,
    output logic [LANES*LANE_W-1:0] chn_alu_out_rsc_z,
    output logic                    chn_alu_out_rsc_lz,
    input  logic                    chn_alu_out_rsc_vz
`ifdef SDP_X_ALU_PERF_CNT_EN
    ,
    output logic [31:0]             alu_stall_cnt
`endif
);

    logic s1_v;
    logic s2_v;
    logic s1_ready;
    logic s2_ready;

    logic [LANES*LANE_W-1:0] s1_z;
    logic [LANES*LANE_W-1:0] alu_z;
    logic [LANE_W-1:0]       s1_op;
    logic [1:0]              s1_algo;
    logic [1:0]              s1_prec;
    logic                    s1_byp;

    assign s2_ready = !s2_v | chn_alu_out_rsc_vz;
    assign s1_ready = !s1_v | s2_ready;

    // No beat is consumed while reset is held.
    assign chn_alu_in_rsc_lz  = chn_alu_in_rsc_vz & s1_ready & !nvdla_core_rst;
    assign chn_alu_out_rsc_lz = s2_v;

    // Stage valid flags advance along the ready chain.
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            s1_v <= 1'b0;
            s2_v <= 1'b0;
        end else begin
            if (s1_ready)
                s1_v <= chn_alu_in_rsc_vz;
            if (s2_ready)
                s2_v <= s1_v;
        end
    end

    // Beat and its config are captured together, scaled operand included.
    always_ff @(posedge nvdla_core_clk) begin
        if (chn_alu_in_rsc_lz) begin
            s1_z    <= chn_alu_in_rsc_z;
            s1_op   <= op_scale(cfg_alu_op, cfg_alu_shift_value);
            s1_algo <= cfg_alu_algo;
            s1_prec <= cfg_precision;
            s1_byp  <= cfg_alu_bypass;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        sdp_x_alu_lane u_lane (
            .data   (s1_z[i*LANE_W +: LANE_W]),
            .op     (s1_op),
            .algo   (s1_algo),
            .prec   (s1_prec),
            .bypass (s1_byp),
            .result (alu_z[i*LANE_W +: LANE_W])
        );
    end

    // Output register loads only on advance, so it holds through stalls.
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst)
            chn_alu_out_rsc_z <= '0;
        else if (s2_ready && s1_v)
            chn_alu_out_rsc_z <= alu_z;
    end

`ifdef SDP_X_ALU_PERF_CNT_EN
    // Count cycles with a held output beat, saturating at all-ones.
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst)
            alu_stall_cnt <= '0;
        else if (s2_v && !chn_alu_out_rsc_vz && alu_stall_cnt != 32'hFFFF_FFFF)
            alu_stall_cnt <= alu_stall_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_sdp_x_alu_stage.sv
// Bench for sdp_x_alu_stage: directed literal cases plus random
// traffic scored against an arithmetic reference model.
module tb_sdp_x_alu_stage;

    localparam int W = 512;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] in_z = '0;
    logic         in_vz = 1'b0;
    logic         in_lz;
    logic         cfg_byp = 1'b0;
    logic [1:0]   cfg_algo = 2'd0;
    logic [15:0]  cfg_op = 16'd0;
    logic [4:0]   cfg_sh = 5'd0;
    logic [1:0]   cfg_prec = 2'd2;
    logic [W-1:0] out_z;
    logic         out_lz;
    logic         out_vz = 1'b1;
`ifdef SDP_X_ALU_PERF_CNT_EN
    logic [31:0]  alu_stall_cnt;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sdp_x_alu_stage dut (
        .nvdla_core_clk      (clk),
        .nvdla_core_rst      (rst),
        .chn_alu_in_rsc_z    (in_z),
        .chn_alu_in_rsc_vz   (in_vz),
        .chn_alu_in_rsc_lz   (in_lz),
        .cfg_alu_bypass      (cfg_byp),
        .cfg_alu_algo        (cfg_algo),
        .cfg_alu_op          (cfg_op),
        .cfg_alu_shift_value (cfg_sh),
        .cfg_precision       (cfg_prec),
        .chn_alu_out_rsc_z   (out_z),
        .chn_alu_out_rsc_lz  (out_lz),
        .chn_alu_out_rsc_vz  (out_vz)
`ifdef SDP_X_ALU_PERF_CNT_EN
        ,
        .alu_stall_cnt       (alu_stall_cnt)
`endif
    );

    task automatic chk(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic over each lane.
    function automatic logic [W-1:0] model(
        input logic [W-1:0] z, input logic byp, input logic [1:0] algo,
        input logic [15:0] op, input logic [4:0] sh, input logic [1:0] prec
    );
        longint o, a, r, lo, hi;
        logic [W-1:0] res;
        o = longint'($signed(op));
        o = o * (longint'(1) << sh);
        if (o > 64'sd2147483647) o = 64'sd2147483647;
        if (o < -64'sd2147483648) o = -64'sd2147483648;
        case (prec)
            2'd0: begin lo = -128; hi = 127; end
            2'd1: begin lo = -32768; hi = 32767; end
            default: begin lo = -64'sd2147483648; hi = 64'sd2147483647; end
        endcase
        res = '0;
        for (int i = 0; i < 16; i++) begin
            a = longint'($signed(z[i*32 +: 32]));
            if (byp) r = a;
            else if (algo == 2'd1) r = (a > o) ? a : o;
            else if (algo == 2'd2) r = (a < o) ? a : o;
            else begin
                r = a + o;
                if (r > hi) r = hi;
                if (r < lo) r = lo;
            end
            res[i*32 +: 32] = r[31:0];
        end
        return res;
    endfunction

    function automatic logic [W-1:0] mk2(input logic [31:0] l0,
                                         input logic [31:0] l1);
        logic [W-1:0] v;
        v = '0;
        v[31:0] = l0;
        v[63:32] = l1;
        return v;
    endfunction

    function automatic logic [W-1:0] rand_beat();
        logic [W-1:0] v;
        for (int i = 0; i < 16; i++)
            if ($urandom % 2 == 0)
                v[i*32 +: 32] = $urandom;
            else
                v[i*32 +: 32] = $urandom_range(0, 511) - 32'd256;
        return v;
    endfunction

    // Downstream ready: 0 always, 1 pattern 1,0,0, 2 random, 3 stalled.
    int bp_mode = 0;
    int bp_cnt = 0;
    always @(posedge clk) begin
        #1;
        case (bp_mode)
            0: out_vz = 1'b1;
            1: begin out_vz = (bp_cnt % 3 == 0); bp_cnt++; end
            2: out_vz = ($urandom % 10) < 7;
            default: out_vz = 1'b0;
        endcase
    end

    // Scoreboard: order, content and stall stability of every beat.
    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_q[$];
    logic [W-1:0] prev_z;
    logic [W-1:0] mon_e;
    logic         prev_stall = 1'b0;
    bit           saw_full = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_lz", W'(out_lz), W'(1));
                chk("stall_z", out_z, prev_z);
            end
            if (out_lz && out_vz) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_beat: got %0h expected none", out_z);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("beat", out_z, mon_e);
                    got_q.push_back(out_z);
                end
            end
            if (in_vz && in_lz)
                exp_q.push_back(model(in_z, cfg_byp, cfg_algo, cfg_op,
                                      cfg_sh, cfg_prec));
            if (in_vz && !in_lz)
                saw_full = 1'b1;
            prev_stall = out_lz && !out_vz;
            prev_z = out_z;
        end
    end

    // Called just after a rising edge; returns just after the accept edge.
    task automatic send(input logic [W-1:0] z, input logic byp,
                        input logic [1:0] algo, input logic [15:0] op,
                        input logic [4:0] sh, input logic [1:0] prec);
        bit ok;
        ok = 1'b0;
        in_z = z; cfg_byp = byp; cfg_algo = algo;
        cfg_op = op; cfg_sh = sh; cfg_prec = prec;
        in_vz = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            ok = in_lz;
            @(posedge clk);
            #1;
            if (ok) break;
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: got no accept expected accept");
        end
        in_vz = 1'b0;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        bp_mode = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !out_lz) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    // One beat into an empty pipe: checks the 2-cycle latency.
    task automatic single(input logic [W-1:0] z, input logic byp,
                          input logic [1:0] algo, input logic [15:0] op,
                          input logic [4:0] sh, input logic [1:0] prec,
                          output logic [W-1:0] res);
        drain();
        send(z, byp, algo, op, sh, prec);
        @(negedge clk);
        chk("lat_not_early", W'(out_lz), W'(0));
        @(negedge clk);
        chk("lat_two", W'(out_lz), W'(1));
        res = out_z;
    endtask

    logic [W-1:0] r;
    logic [W-1:0] bz;
    int start;

    initial begin
        // Reset held with valid input.
        in_vz = 1'b1;
        in_z = rand_beat();
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            chk("rst_out_lz", W'(out_lz), W'(0));
            chk("rst_in_lz", W'(in_lz), W'(0));
            chk("rst_out_z", out_z, W'(0));
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("first_accept", W'(in_lz), W'(1));
        @(posedge clk);
        #1 in_vz = 1'b0;

        // INT8 saturation.
        single(mk2(32'd100, 32'd0), 1'b0, 2'd0, 16'd50, 5'd0, 2'd0, r);
        chk("int8_hi_l0", W'(r[31:0]), W'(32'd127));
        chk("int8_hi_l1", W'(r[63:32]), W'(32'd50));
        single(mk2(32'd0, -32'sd100), 1'b0, 2'd0, -16'sd50, 5'd0, 2'd0, r);
        chk("int8_lo_l0", W'(r[31:0]), W'(32'hFFFF_FFCE));
        chk("int8_lo_l1", W'(r[63:32]), W'(32'hFFFF_FF80));

        // INT16 saturation.
        single(mk2(32'd32000, 32'd0), 1'b0, 2'd0, 16'd1000, 5'd0, 2'd1, r);
        chk("int16_l0", W'(r[31:0]), W'(32'd32767));
        chk("int16_l1", W'(r[63:32]), W'(32'd1000));

        // INT32 with operand shift saturating.
        single(mk2(32'd5, 32'h8000_0001), 1'b0, 2'd0, 16'h7FFF, 5'd20,
               2'd2, r);
        chk("int32_l0", W'(r[31:0]), W'(32'h7FFF_FFFF));
        chk("int32_l1", W'(r[63:32]), W'(32'd0));

        // MAX / MIN / reserved / bypass.
        single(mk2(-32'sd5, 32'd7), 1'b0, 2'd1, 16'd0, 5'd0, 2'd2, r);
        chk("max_l0", W'(r[31:0]), W'(32'd0));
        chk("max_l1", W'(r[63:32]), W'(32'd7));
        single(mk2(-32'sd5, 32'd7), 1'b0, 2'd2, 16'd0, 5'd0, 2'd2, r);
        chk("min_l0", W'(r[31:0]), W'(32'hFFFF_FFFB));
        chk("min_l1", W'(r[63:32]), W'(32'd0));
        single(mk2(32'd1, 32'd2), 1'b0, 2'd3, 16'd3, 5'd0, 2'd2, r);
        chk("rsvd_l0", W'(r[31:0]), W'(32'd4));
        chk("rsvd_l1", W'(r[63:32]), W'(32'd5));
        bz = rand_beat();
        single(bz, 1'b1, 2'd1, 16'd123, 5'd3, 2'd0, r);
        chk("bypass", r, bz);

        // Backpressure streaming.
        drain();
        saw_full = 1'b0;
        start = got_q.size();
        bp_mode = 1;
        for (int b = 0; b < 8; b++)
            send(rand_beat(), 1'b0, 2'($urandom), 16'($urandom), 5'd0, 2'd2);
        drain();
        chk("bp_count", W'(got_q.size() - start), W'(8));
        chk("bp_in_lz_drop", W'(saw_full), W'(1));

        // Mid-stream config change.
        start = got_q.size();
        send(mk2(32'd0, 32'd0), 1'b0, 2'd0, 16'd10, 5'd0, 2'd2);
        send(mk2(32'd0, 32'd0), 1'b0, 2'd0, 16'd10, 5'd0, 2'd2);
        send(mk2(32'd0, 32'd0), 1'b0, 2'd0, 16'd20, 5'd0, 2'd2);
        send(mk2(32'd0, 32'd0), 1'b0, 2'd0, 16'd20, 5'd0, 2'd2);
        drain();
        chk("cfg_b1", W'(got_q[start][31:0]), W'(32'd10));
        chk("cfg_b2", W'(got_q[start+1][31:0]), W'(32'd10));
        chk("cfg_b3", W'(got_q[start+2][31:0]), W'(32'd20));
        chk("cfg_b4", W'(got_q[start+3][31:0]), W'(32'd20));

        // Reset with two beats in flight.
        bp_mode = 3;
        send(rand_beat(), 1'b0, 2'd0, 16'd1, 5'd0, 2'd2);
        send(rand_beat(), 1'b0, 2'd0, 16'd2, 5'd0, 2'd2);
        rst = 1'b1;
        in_vz = 1'b1;
        @(negedge clk);
        chk("mid_rst_lz_pre", W'(out_lz), W'(1));
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_lz", W'(out_lz), W'(0));
        chk("mid_rst_in_lz", W'(in_lz), W'(0));
        @(posedge clk);
        #1;
        in_vz = 1'b0;
        rst = 1'b0;
        bp_mode = 0;
        @(negedge clk);
        chk("mid_rst_z", out_z, W'(0));
        repeat (5) @(negedge clk);
        chk("no_stale", W'(out_lz), W'(0));
        @(posedge clk);
        #1;

        // Random traffic against the model.
        bp_mode = 2;
        for (int n = 0; n < 400; n++) begin
            in_vz = ($urandom % 4) != 0;
            in_z = rand_beat();
            cfg_byp = ($urandom % 8) == 0;
            cfg_algo = 2'($urandom);
            cfg_op = 16'($urandom);
            cfg_sh = 5'($urandom);
            cfg_prec = 2'($urandom);
            @(posedge clk);
            #1;
        end
        in_vz = 1'b0;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sdp_x_alu_stage.md
Name: sdp_x_alu_stage

Overview:
- X-datapath ALU stage of SDP; sits directly upstream of the X ReLU stage and produces its 512-bit input beat.
- Applies a per-layer operand (shifted, sign-extended) to 16 signed 32-bit lanes via SUM / MAX / MIN, or passes data through on bypass.
- Two-stage pipeline with full backpressure, using the same vz/lz channel style as neighbouring SDP stages.

Parameters:
- LANES, 16, number of 32-bit lanes per beat
- LANE_W, 32, lane width in bits
- OP_W, 16, operand width in bits

Ports:
- nvdla_core_clk  in  1  core clock
- nvdla_core_rst  in  1  synchronous active-high reset
- chn_alu_in_rsc_z  in  LANES*LANE_W  input beat; lane i = bits [32i+31:32i], two's complement
- chn_alu_in_rsc_vz  in  1  input valid
- chn_alu_in_rsc_lz  out  1  input accept: beat consumed this cycle
- cfg_alu_bypass  in  1  1 = pass data unchanged
- cfg_alu_algo  in  2  0 = SUM, 1 = MAX, 2 = MIN, 3 = reserved (behaves as SUM)
- cfg_alu_op  in  OP_W  signed operand
- cfg_alu_shift_value  in  5  left shift applied to operand
- cfg_precision  in  2  0 = INT8, 1 = INT16, 2/3 = INT32 saturation range
- chn_alu_out_rsc_z  out  LANES*LANE_W  result beat to ReLU stage
- chn_alu_out_rsc_lz  out  1  output valid
- chn_alu_out_rsc_vz  in  1  downstream ready

Behaviour:
- Clock/reset: one clock, nvdla_core_clk; nvdla_core_rst is synchronous, active-high. Reset clears both stage-valid flags. Outputs after reset: chn_alu_out_rsc_lz = 0, chn_alu_out_rsc_z = 0. Data registers need no reset except the output register, which resets to 0.
- Input accept: chn_alu_in_rsc_lz = chn_alu_in_rsc_vz & s1_ready. It is combinational, not registered.
- Ready chain: s1_ready = !s1_v | s2_ready; s2_ready = !s2_v | chn_alu_out_rsc_vz.
- Config capture: cfg_* is sampled with the beat into stage 1 (S1), so a mid-stream config change affects only later beats.
- Stage 1: op_ext = sign_extend(cfg_alu_op) << shift, computed at 48 bits. The result is saturated to the signed 32-bit range and registered with the data.
- Stage 2, per lane:
  - SUM: 33-bit signed add, then saturate to the precision range. INT8 = [-128, 127]; INT16 = [-32768, 32767]; INT32 = full range.
  - MAX / MIN: signed compare, no saturation.
  - Bypass: data copied unchanged; operand ignored.
- Stage advance: S1 moves to S2 when s2_ready. S2 output holds stable while lz = 1 and vz = 0; no data change while stalled.
- Latency: 2 cycles from accept to output valid with no stall. Throughput is 1 beat/cycle when vz is held high.
- Simultaneous events: accept and output handshake in the same cycle is legal at full rate; there are no bubbles.
- Reset mid-operation: in-flight beats are dropped; lz falls in the cycle after reset is asserted.
- Empty pipeline with vz = 0: lz = 0 and outputs hold their last value.

Optional Feature:
- Macro: SDP_X_ALU_PERF_CNT_EN.
- When defined, adds output port alu_stall_cnt (out, 32).
  - Increments each cycle where chn_alu_out_rsc_lz & !chn_alu_out_rsc_vz.
  - Saturates at 0xFFFFFFFF; clears on reset.
- When undefined: the port and logic are absent; datapath behaviour is identical.

Decomposition:
- Shared package sdp_x_pkg holds:
  - enum alu_algo_e {SUM, MAX, MIN}
  - precision encodings
  - constants INT8_MAX/MIN, INT16_MAX/MIN, INT32_MAX/MIN
  - LANE_W
- One sub-module, sdp_x_alu_lane: a combinational single-lane SUM/MAX/MIN/saturate unit, instantiated LANES times in stage 2.

Test Plan:
- Reset: hold reset 3 cycles with input valid -> lz = 0, in_lz = 0, out_z = 0 throughout; first accept on the cycle after deassert.
- SUM INT8 saturation: lane0 = 100, op = 50, shift = 0, precision = 0 -> lane0 = 127 two cycles later. Lane1 = -100, op = -50 -> -128.
- SUM INT32 with shift: op = 0x7FFF, shift = 20 -> operand saturates to 0x7FFFFFFF; lane = 5 -> 0x7FFFFFFF. Lane = -0x7FFFFFFF -> 0.
- MAX / MIN: algo = MAX, op = 0, lanes {-5, 7} -> {0, 7}. Algo = MIN -> {-5, 0}. Bypass = 1, any algo -> output equals input bit-exactly.
- Backpressure: stream 8 beats with out_vz toggling 1,0,0,1,... -> all 8 beats arrive in order, none lost or duplicated; in_lz deasserts when both stages are full; out_z is stable during stalls.
- Config change and reset mid-stream:
  - Change op between beat 2 and beat 3 -> beats 1–2 use the old op, beat 3+ the new op.
  - Assert reset with 2 beats in flight -> lz = 0 the next cycle; no stale beat appears after reset.
